// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: words, ALU op codes, operand-source and forward selects,
// plus the ID/EX register layout and its bubble value.
package cpu_types_pkg;

    typedef logic [31:0] word_t;
    typedef logic [4:0]  regbits_t;

    typedef enum logic [3:0] {
        ALU_SLL  = 4'd0,
        ALU_SRL  = 4'd1,
        ALU_SRA  = 4'd2,
        ALU_ADD  = 4'd3,
        ALU_ADDU = 4'd4,
        ALU_SUB  = 4'd5,
        ALU_SUBU = 4'd6,
        ALU_AND  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_XOR  = 4'd9,
        ALU_NOR  = 4'd10,
        ALU_SLT  = 4'd11,
        ALU_SLTU = 4'd12
    } aluop_t;

    typedef enum logic [1:0] {
        SRC_RT   = 2'd0,
        SRC_SEXT = 2'd1,
        SRC_ZEXT = 2'd2,
        SRC_LUI  = 2'd3
    } alusrc_t;

    typedef enum logic [1:0] {
        FWD_NONE = 2'd0,
        FWD_EXM  = 2'd1,
        FWD_MWB  = 2'd2
    } fwd_sel_t;

    localparam aluop_t   BUBBLE_ALUOP = ALU_SLL;
    localparam word_t    BUBBLE_WORD  = 32'h0000_0000;
    localparam regbits_t REG_ZERO     = 5'd0;

    typedef struct packed {
        logic     valid;
        aluop_t   aluop;
        regbits_t rs;
        regbits_t rt;
        word_t    rs_data;
        word_t    rt_data;
        word_t    imm_ext;
        regbits_t shamt;
        alusrc_t  alusrc;
        logic     shift;
        regbits_t rd;
        logic     regwr;
    } ex_reg_t;

    localparam ex_reg_t EX_BUBBLE = '{
        valid:   1'b0,
        aluop:   BUBBLE_ALUOP,
        rs:      REG_ZERO,
        rt:      REG_ZERO,
        rs_data: BUBBLE_WORD,
        rt_data: BUBBLE_WORD,
        imm_ext: BUBBLE_WORD,
        shamt:   REG_ZERO,
        alusrc:  SRC_RT,
        shift:   1'b0,
        rd:      REG_ZERO,
        regwr:   1'b0
    };

    // The immediate is widened once at capture so the EX path only muxes.
    function automatic word_t prep_imm(input alusrc_t src, input logic [15:0] imm);
        word_t w_res;
        case (src)
            SRC_SEXT: w_res = {{16{imm[15]}}, imm};
            SRC_ZEXT: w_res = {16'h0000, imm};
            SRC_LUI:  w_res = {imm, 16'h0000};
            default:  w_res = {{16{imm[15]}}, imm};
        endcase
        return w_res;
    endfunction

endpackage

// File: rtl/ex_operand_stage_forward_mux.sv
// forward_mux: picks one operand from EX/MEM, MEM/WB or the stored register value.
// Bypass logic is present only when EX_FORWARD_EN is defined.
module forward_mux
    import cpu_types_pkg::*;
(
    input  logic [4:0]  i_reg,
    input  logic [31:0] i_stored,
    input  logic        i_exm_regwr,
    input  logic [4:0]  i_exm_rd,
    input  logic [31:0] i_exm_data,
    input  logic        i_mwb_regwr,
    input  logic [4:0]  i_mwb_rd,
    input  logic [31:0] i_mwb_data,
    output logic [31:0] o_data,
    output logic [1:0]  o_sel
);

`ifdef EX_FORWARD_EN
    logic w_exm_hit;
    logic w_mwb_hit;

    // r0 is hardwired, so a write to it must never bypass.
    assign w_exm_hit = i_exm_regwr && (i_exm_rd != REG_ZERO) && (i_exm_rd == i_reg);
    assign w_mwb_hit = i_mwb_regwr && (i_mwb_rd != REG_ZERO) && (i_mwb_rd == i_reg);

    // Youngest producer wins: EX/MEM before MEM/WB.
    always_comb begin
        o_data = i_stored;
        o_sel  = FWD_NONE;
        if (w_exm_hit) begin
            o_data = i_exm_data;
            o_sel  = FWD_EXM;
        end else if (w_mwb_hit) begin
            o_data = i_mwb_data;
            o_sel  = FWD_MWB;
        end else begin
            o_data = i_stored;
            o_sel  = FWD_NONE;
        end
    end
`else
    logic w_unused_fwd;

    assign w_unused_fwd = ^{i_reg, i_exm_regwr, i_exm_rd, i_exm_data,
                            i_mwb_regwr, i_mwb_rd, i_mwb_data};
    assign o_data = i_stored;
    assign o_sel  = FWD_NONE;
`endif

endmodule

// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register with operand formation for the ALU.
// Define EX_FORWARD_EN to enable EX/MEM and MEM/WB forwarding and stall refresh.
module ex_operand_stage
    import cpu_types_pkg::*;
(
    input  logic        CLK,
    input  logic        RST,
    input  logic        id_valid,
    input  logic [3:0]  id_aluop,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic [31:0] id_rs_data,
    input  logic [31:0] id_rt_data,
    input  logic [15:0] id_imm,
    input  logic [4:0]  id_shamt,
    input  logic [1:0]  id_alusrc,
    input  logic        id_shift,
    input  logic [4:0]  id_rd,
    input  logic        id_regwr,
    input  logic        stall,
    input  logic        flush,
    input  logic        exm_regwr,
    input  logic [4:0]  exm_rd,
    input  logic [31:0] exm_data,
    input  logic        mwb_regwr,
    input  logic [4:0]  mwb_rd,
    input  logic [31:0] mwb_data,
    output logic        ex_valid,
    output logic [3:0]  ex_aluop,
    output logic [31:0] ex_port_a,
    output logic [31:0] ex_port_b,
    output logic [4:0]  ex_rd,
    output logic        ex_regwr,
    output logic [1:0]  ex_fwd_a,
    output logic [1:0]  ex_fwd_b
);

    ex_reg_t     r_stage;
    ex_reg_t     w_load;
    logic [31:0] w_fwd_a_data;
    logic [31:0] w_fwd_b_data;
    logic [1:0]  w_fwd_a_sel;
    logic [1:0]  w_fwd_b_sel;

    // Next contents when decode is accepted; an invalid slot becomes a bubble.
    always_comb begin
        w_load = EX_BUBBLE;
        if (id_valid) begin
            w_load.valid   = 1'b1;
            w_load.aluop   = aluop_t'(id_aluop);
            w_load.rs      = id_rs;
            w_load.rt      = id_rt;
            w_load.rs_data = id_rs_data;
            w_load.rt_data = id_rt_data;
            w_load.imm_ext = prep_imm(alusrc_t'(id_alusrc), id_imm);
            w_load.shamt   = id_shamt;
            w_load.alusrc  = alusrc_t'(id_alusrc);
            w_load.shift   = id_shift;
            w_load.rd      = id_rd;
            w_load.regwr   = id_regwr;
        end else begin
            w_load = EX_BUBBLE;
        end
    end

`ifdef EX_FORWARD_EN
    logic w_mwb_hit_rs;
    logic w_mwb_hit_rt;

    assign w_mwb_hit_rs = mwb_regwr && (mwb_rd != REG_ZERO) && (mwb_rd == r_stage.rs);
    assign w_mwb_hit_rt = mwb_regwr && (mwb_rd != REG_ZERO) && (mwb_rd == r_stage.rt);
`endif

    // Pipeline register: flush beats stall; a held slot still absorbs retiring writes.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_stage <= EX_BUBBLE;
        end else if (flush) begin
            r_stage <= EX_BUBBLE;
        end else if (stall) begin
`ifdef EX_FORWARD_EN
            if (w_mwb_hit_rs) begin
                r_stage.rs_data <= mwb_data;
            end
            if (w_mwb_hit_rt) begin
                r_stage.rt_data <= mwb_data;
            end
`else
            r_stage <= r_stage;
`endif
        end else begin
            r_stage <= w_load;
        end
    end

    forward_mux u_fwd_a (
        .i_reg       (r_stage.rs),
        .i_stored    (r_stage.rs_data),
        .i_exm_regwr (exm_regwr),
        .i_exm_rd    (exm_rd),
        .i_exm_data  (exm_data),
        .i_mwb_regwr (mwb_regwr),
        .i_mwb_rd    (mwb_rd),
        .i_mwb_data  (mwb_data),
        .o_data      (w_fwd_a_data),
        .o_sel       (w_fwd_a_sel)
    );

    forward_mux u_fwd_b (
        .i_reg       (r_stage.rt),
        .i_stored    (r_stage.rt_data),
        .i_exm_regwr (exm_regwr),
        .i_exm_rd    (exm_rd),
        .i_exm_data  (exm_data),
        .i_mwb_regwr (mwb_regwr),
        .i_mwb_rd    (mwb_rd),
        .i_mwb_data  (mwb_data),
        .o_data      (w_fwd_b_data),
        .o_sel       (w_fwd_b_sel)
    );

    // Operand steering; shifts take the rt value on port A and shamt on port B.
    always_comb begin
        ex_port_a = BUBBLE_WORD;
        ex_port_b = BUBBLE_WORD;
        ex_fwd_a  = FWD_NONE;
        ex_fwd_b  = FWD_NONE;
        if (!r_stage.valid) begin
            ex_port_a = BUBBLE_WORD;
            ex_port_b = BUBBLE_WORD;
            ex_fwd_a  = FWD_NONE;
            ex_fwd_b  = FWD_NONE;
        end else if (r_stage.shift) begin
            ex_port_a = w_fwd_b_data;
            ex_port_b = {27'd0, r_stage.shamt};
            ex_fwd_a  = w_fwd_a_sel;
            ex_fwd_b  = w_fwd_b_sel;
        end else if (r_stage.alusrc == SRC_RT) begin
            ex_port_a = w_fwd_a_data;
            ex_port_b = w_fwd_b_data;
            ex_fwd_a  = w_fwd_a_sel;
            ex_fwd_b  = w_fwd_b_sel;
        end else begin
            ex_port_a = w_fwd_a_data;
            ex_port_b = r_stage.imm_ext;
            ex_fwd_a  = w_fwd_a_sel;
            ex_fwd_b  = w_fwd_b_sel;
        end
    end

    assign ex_valid = r_stage.valid;
    assign ex_aluop = r_stage.aluop;
    assign ex_rd    = r_stage.rd;
    assign ex_regwr = r_stage.regwr;

endmodule
